// File: rtl/arc4_pkg.sv
// arc4_pkg: shared FSM states, S-box size, key length and the key_byte helper for the arc4 units
package arc4_pkg;
  localparam int SBOX_SIZE = 256;
  localparam int KEY_BYTES = 3;
  typedef enum logic [3:0] {IDLE, INIT, KSA_RI, KSA_RJ, KSA_WI, KSA_WJ, LEN, PRGA_LEN, PRGA_RUN, DONE} state_t;
  typedef enum logic [2:0] {KS_IDLE, KS_RI, KS_RJ, KS_WI, KS_WJ, KS_RP, KS_CT} ks_state_t;
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key, input logic [1:0] idx);
    return key[8*(KEY_BYTES-1-int'(idx)) +: 8];
  endfunction
endpackage

// File: rtl/arc4_keystream.sv
// arc4_keystream: PRGA sequencer (en/len/rdy/done, S RAM port, pt read port, ct write port)
module arc4_keystream
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_len,
  output logic       o_rdy,
  output logic       o_done,
  output logic [7:0] o_s_addr,
  input  logic [7:0] i_s_rddata,
  output logic [7:0] o_s_wrdata,
  output logic       o_s_wren,
  output logic [7:0] o_pt_addr,
  input  logic [7:0] i_pt_rddata,
  output logic [7:0] o_ct_addr,
  output logic [7:0] o_ct_wrdata,
  output logic       o_ct_wren
);
  ks_state_t r_state, w_next;
  logic [7:0] r_i, r_j, r_k, r_len, r_si, r_sj, r_pt;
  logic [7:0] w_i1, w_j1;
  logic w_last;
  assign w_i1 = r_i + 8'd1;
  assign w_j1 = r_j + i_s_rddata;
  assign w_last = r_k == r_len - 8'd1;
  assign o_rdy = r_state == KS_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= KS_IDLE;
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_len <= '0;
      r_si <= '0;
      r_sj <= '0;
      r_pt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == KS_IDLE && i_en) begin
        r_i <= '0;
        r_j <= '0;
        r_k <= 8'd1;
        r_len <= i_len;
      end
      if (r_state == KS_RI) r_i <= w_i1;
      if (r_state == KS_RJ) begin
        r_j <= w_j1;
        r_si <= i_s_rddata;
        r_pt <= i_pt_rddata;
      end
      if (r_state == KS_WI) r_sj <= i_s_rddata;
      if (r_state == KS_CT) r_k <= r_k + 8'd1;
    end
  always_comb begin
    w_next = r_state;
    o_done = 1'b0;
    o_s_addr = '0;
    o_s_wrdata = '0;
    o_s_wren = 1'b0;
    o_pt_addr = '0;
    o_ct_addr = '0;
    o_ct_wrdata = '0;
    o_ct_wren = 1'b0;
    case (r_state)
      KS_IDLE: w_next = i_en ? KS_RI : KS_IDLE;
      KS_RI: begin
        o_s_addr = w_i1;
        o_pt_addr = r_k;
        w_next = KS_RJ;
      end
      KS_RJ: begin
        o_s_addr = w_j1;
        w_next = KS_WI;
      end
      KS_WI: begin
        o_s_addr = r_i;
        o_s_wrdata = i_s_rddata;
        o_s_wren = 1'b1;
        w_next = KS_WJ;
      end
      KS_WJ: begin
        o_s_addr = r_j;
        o_s_wrdata = r_si;
        o_s_wren = 1'b1;
        w_next = KS_RP;
      end
      KS_RP: begin
        o_s_addr = r_si + r_sj;
        w_next = KS_CT;
      end
      KS_CT: begin
        o_ct_addr = r_k;
        o_ct_wrdata = r_pt ^ i_s_rddata;
        o_ct_wren = 1'b1;
        o_done = w_last;
        w_next = w_last ? KS_IDLE : KS_RI;
      end
      default: w_next = KS_IDLE;
    endcase
  end
endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor (en/rdy/key in; S RAM, pt read and ct write ports) owning INIT, KSA, LEN and S-port arbitration
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);
  state_t r_state, w_next;
  logic [8:0] r_cnt;
  logic [7:0] r_j, r_si;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [1:0] r_kidx;
  logic [7:0] w_jn;
  logic w_cnt_end, w_ks_en, w_ks_rdy, w_ks_done;
  logic [7:0] w_ks_s_addr, w_ks_s_wrdata, w_ks_pt_addr, w_ks_ct_addr, w_ks_ct_wrdata;
  logic w_ks_s_wren, w_ks_ct_wren;
  assign w_jn = r_j + s_rddata + key_byte(r_key, r_kidx);
  assign w_cnt_end = r_cnt == 9'(SBOX_SIZE - 1);
  arc4_keystream u_ks (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_ks_en),
    .i_len      (pt_rddata),
    .o_rdy      (w_ks_rdy),
    .o_done     (w_ks_done),
    .o_s_addr   (w_ks_s_addr),
    .i_s_rddata (s_rddata),
    .o_s_wrdata (w_ks_s_wrdata),
    .o_s_wren   (w_ks_s_wren),
    .o_pt_addr  (w_ks_pt_addr),
    .i_pt_rddata(pt_rddata),
    .o_ct_addr  (w_ks_ct_addr),
    .o_ct_wrdata(w_ks_ct_wrdata),
    .o_ct_wren  (w_ks_ct_wren)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_j <= '0;
      r_si <= '0;
      r_key <= '0;
      r_kidx <= '0;
    end else begin
      r_state <= w_next;
      if (rdy && en) begin
        r_key <= key;
        r_cnt <= '0;
        r_j <= '0;
        r_kidx <= '0;
      end
      if (r_state == INIT || r_state == KSA_WJ) r_cnt <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
      if (r_state == KSA_WJ) r_kidx <= r_kidx == 2'(KEY_BYTES - 1) ? 2'd0 : r_kidx + 2'd1;
      if (r_state == KSA_RJ) begin
        r_j <= w_jn;
        r_si <= s_rddata;
      end
    end
  always_comb begin
    w_next = r_state;
    rdy = 1'b0;
    w_ks_en = 1'b0;
    s_addr = '0;
    s_wrdata = '0;
    s_wren = 1'b0;
    pt_addr = '0;
    ct_addr = '0;
    ct_wrdata = '0;
    ct_wren = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        rdy = 1'b1;
        w_next = en ? INIT : IDLE;
      end
      INIT: begin
        s_addr = r_cnt[7:0];
        s_wrdata = r_cnt[7:0];
        s_wren = 1'b1;
        w_next = w_cnt_end ? KSA_RI : INIT;
      end
      KSA_RI: begin
        s_addr = r_cnt[7:0];
        w_next = KSA_RJ;
      end
      KSA_RJ: begin
        s_addr = w_jn;
        w_next = KSA_WI;
      end
      KSA_WI: begin
        s_addr = r_cnt[7:0];
        s_wrdata = s_rddata;
        s_wren = 1'b1;
        w_next = KSA_WJ;
      end
      KSA_WJ: begin
        s_addr = r_j;
        s_wrdata = r_si;
        s_wren = 1'b1;
        w_next = w_cnt_end ? LEN : KSA_RI;
      end
      LEN: w_next = PRGA_LEN;
      PRGA_LEN: begin
        ct_wrdata = pt_rddata;
        ct_wren = 1'b1;
        w_ks_en = pt_rddata > 8'd1 && w_ks_rdy;
        w_next = w_ks_en ? PRGA_RUN : DONE;
      end
      PRGA_RUN: begin
        s_addr = w_ks_s_addr;
        s_wrdata = w_ks_s_wrdata;
        s_wren = w_ks_s_wren;
        pt_addr = w_ks_pt_addr;
        ct_addr = w_ks_ct_addr;
        ct_wrdata = w_ks_ct_wrdata;
        ct_wren = w_ks_ct_wren;
        w_next = w_ks_done ? DONE : PRGA_RUN;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: randomized self-checking bench for arc4_encrypt against a behavioural RC4 model
module tb_arc4_encrypt;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rdy;
  logic [23:0] key = '0;
  logic [7:0] s_addr, s_rddata = '0, s_wrdata, pt_addr, pt_rddata = '0, ct_addr, ct_wrdata;
  logic s_wren, ct_wren;
  logic [7:0] s_mem[256], pt_mem[256], ct_mem[256], orig[256], exp_s[256];
  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, last_wr = -1, ct_wr_cnt = 0;
  logic [7:0] lit[9] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A};

  arc4_encrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    s_rddata <= s_mem[s_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    wr_t e;
    if (!rst) begin
      chk("write_exclusive", 32'(s_wren & ct_wren), 32'd0);
      if (ct_wren) begin
        ct_wr_cnt++;
        last_wr = cyc;
        if (exp_q.size() == 0) chk("ct_unexpected_write_addr", 32'(ct_addr), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("ct_addr", 32'(ct_addr), 32'(e.a));
          chk("ct_data", 32'(ct_wrdata), 32'(e.d));
        end
      end
    end
  end

  task automatic model(input logic [23:0] k);
    logic [7:0] s[256];
    logic [7:0] i, j, t, pad;
    int len;
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + 8'(k >> (8 * (2 - n % 3)));
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    exp_q.delete();
    len = int'(pt_mem[0]);
    exp_q.push_back(wr_t'{8'd0, pt_mem[0]});
    i = 0;
    j = 0;
    for (int n = 1; n < len; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      pad = s[8'(s[i] + s[j])];
      exp_q.push_back(wr_t'{8'(n), pt_mem[n] ^ pad});
    end
    exp_s = s;
  endtask

  task automatic prep(input int len);
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'($urandom);
      ct_mem[n] = 8'h5A;
    end
    pt_mem[0] = 8'(len);
  endtask

  task automatic run_job(input logic [23:0] k, input bit spam, input string tag);
    int exp_cnt, bad;
    logic [255:0] seen;
    model(k);
    exp_cnt = exp_q.size();
    ct_wr_cnt = 0;
    key = k;
    en = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 6000; n++) begin
      if (rdy) break;
      en = spam ? 1'($urandom) : 1'b0;
      key = 24'($urandom);
      @(negedge clk);
    end
    en = 1'b0;
    chk({tag, "_rdy_in_budget"}, 32'(rdy), 32'd1);
    chk({tag, "_rdy_after_last_ct"}, 32'(cyc), 32'(last_wr + 1));
    chk({tag, "_ct_write_count"}, 32'(ct_wr_cnt), 32'(exp_cnt));
    chk({tag, "_pending_ct"}, 32'(exp_q.size()), 32'd0);
    bad = 0;
    seen = '0;
    for (int n = 0; n < 256; n++) begin
      if (s_mem[n] !== exp_s[n]) bad++;
      seen[s_mem[n]] = 1'b1;
    end
    chk({tag, "_s_final_mismatches"}, 32'(bad), 32'd0);
    chk({tag, "_s_permutation"}, 32'(&seen), 32'd1);
  endtask

  task automatic test_key(input string tag);
    string p = "Plaintext";
    prep(9);
    for (int n = 0; n < 9; n++) pt_mem[n + 1] = p[n];
    model(24'h4B6579);
    for (int n = 0; n < 9; n++) chk({tag, "_model_pin"}, 32'(exp_q[n].d), 32'(lit[n]));
    run_job(24'h4B6579, 1'b0, tag);
    for (int n = 0; n < 9; n++) chk({tag, "_ct_lit"}, 32'(ct_mem[n]), 32'(lit[n]));
    chk({tag, "_ct9_untouched"}, 32'(ct_mem[9]), 32'h5A);
  endtask

  initial begin
    int len;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_s_wren", 32'(s_wren), 32'd0);
    chk("reset_ct_wren", 32'(ct_wren), 32'd0);
    chk("reset_addrs", {s_addr, pt_addr, ct_addr, 8'd0}, 32'd0);
    chk("reset_data", {s_wrdata, ct_wrdata, 16'd0}, 32'd0);
    @(negedge clk);
    test_key("key_vector");
    len = $urandom_range(2, 60);
    prep(len);
    for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
    run_job(24'h000018, 1'b0, "rt_enc");
    for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
    run_job(24'h000018, 1'b0, "rt_dec");
    for (int n = 0; n < len; n++) chk("roundtrip", 32'(ct_mem[n]), 32'(orig[n]));
    for (int l = 0; l < 2; l++) begin
      prep(l);
      run_job(24'($urandom), 1'b0, "short_len");
      chk("short_ct0", 32'(ct_mem[0]), 32'(l));
      chk("short_ct1_untouched", 32'(ct_mem[1]), 32'h5A);
    end
    prep(20);
    run_job(24'($urandom), 1'b1, "en_spam");
    chk("en_spam_count_eq_L", 32'(ct_wr_cnt), 32'd20);
    prep(9);
    key = 24'h4B6579;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (400) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_rdy", 32'(rdy), 32'd1);
    chk("midrst_no_writes", 32'(s_wren | ct_wren), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_idle_writes", 32'(s_wren | ct_wren), 32'd0);
    end
    test_key("after_rst");
    prep(255);
    run_job(24'($urandom), 1'b0, "len255");
    chk("len255_ct255_untouched", 32'(ct_mem[255]), 32'h5A);
    repeat (3) begin
      prep($urandom_range(0, 255));
      run_job(24'($urandom), 1'b0, "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
